pe_array_sequencer: RTL and testbench
=====================================

# pe_array_sequencer

Issue-side sequencer for the 16-lane bit-serial PE array. It accepts one array instruction at a time over a valid/ready handshake. It then drives the broadcast control bus that every PE block consumes in lockstep: BRAM port addresses and write enables, ALU select, the bit-serial step `count`, and the east/west/south/north move strobes. It sits between the host instruction queue and the PE array and generates every cycle-level control the PEs need to run one ALU operation or one neighbour move over a `LENGTH`-row bit-plane operand.

## Interface
- `LENGTH`, 32: operand width in bit-plane rows. Must be even, 2..62.
- `AW`, 10: BRAM row address width.
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-low; clock `clk`
- `ins_valid`  in  1  instruction offered
- `ins_ready`  out  1  sequencer idle; instruction accepted on a `clk` edge with `ins_valid & ins_ready`
- `ins_kind`  in  3  0=ALU, 1=east, 2=west, 3=south, 4=north, 5..7=NOP
- `ins_op`  in  4  ALU select, used only for kind 0
- `ins_srca`  in  AW  first row of operand A (ALU) or of the region to move
- `ins_srcb`  in  AW  first row of operand B (ALU only)
- `ins_dst`  in  AW  first row of the result (ALU only)
- `addra`, `addrb`  out  AW  PE BRAM port A/B row address
- `wea`, `web`  out  1  PE BRAM port A/B write enable
- `alu_sel`  out  4  PE ALU select
- `count`  out  7  bit-serial step index to the PE ALUs
- `east`, `west`, `south`, `north`  out  1  PE move strobes, at most one high
- `busy`  out  1  instruction in progress
- `done`  out  1  one-cycle completion pulse

## Operation
- States: IDLE, ALU_RUN, MOVE_RUN. An internal step counter `c` runs from 0 upward in the RUN states.
- IDLE: `ins_ready`=1. On accept, latch all `ins_*` fields and clear `c`.
  - kind 0 → ALU_RUN.
  - kinds 1-4 → MOVE_RUN.
  - kinds 5-7 → stay IDLE and pulse `done` next cycle; no write enables are raised.
- ALU_RUN, `c` = 0..2·LENGTH+3, with `count`=`c`, `alu_sel`=latched op, bit index i=`c`>>1:
  - `c` even and < 2·LENGTH: `addra`=srca+i, `addrb`=srcb+i, `wea`=`web`=0.
  - `c` odd and < 2·LENGTH: `addra`=dst+i, `addrb` held, `wea`=1, `web`=0.
  - `c` = 2·LENGTH..2·LENGTH+3: drain cycles; addresses hold, `wea`=`web`=0.
  - After `c`=2·LENGTH+3 → IDLE.
- MOVE_RUN, `c` = 0..LENGTH-1, row pair j=`c`>>1, update in place:
  - `addra`=srca+2j, `addrb`=srca+2j+1 on both cycles of the pair.
  - `c` even: read cycle; all write enables and strobes are 0.
  - `c` odd: `wea`=`web`=1 and the direction strobe for the latched kind is 1.
  - After `c`=LENGTH-1 → IDLE.
- All address arithmetic is modulo 2^AW (wraps 0x3FF→0x000 at AW=10).
- `busy` = state ≠ IDLE.
- `done` is registered and high for exactly one cycle: the first IDLE cycle after a RUN, or the cycle after a NOP accept.
- Outside the RUN states: `count`=0, `alu_sel`=0, all strobes and enables 0, addresses hold their last value.
- `ins_valid` while `busy` is ignored; nothing is latched.

## Timing
- All outputs are registered.
- Reset: state IDLE, `addra`=`addrb`=0, `wea`=`web`=0, `alu_sel`=0, `count`=0, all strobes 0, `busy`=0, `done`=0, `ins_ready`=1 from the first cycle after reset deasserts.
- Reset low mid-instruction: the sequencer aborts at that edge and all outputs take their reset values the next cycle. No further writes are issued and no `done` pulse is produced.
- Accept at edge T: step `c`=0 is presented in cycle T+1.
- ALU instruction: last step in cycle T+2·LENGTH+4; `done` and `ins_ready` high in cycle T+2·LENGTH+5. A back-to-back instruction can be accepted on that edge.
- Move instruction: last step in cycle T+LENGTH; `done` in cycle T+LENGTH+1.
- NOP: `done` in cycle T+1.
- PE BRAM read latency is 1 cycle. Data read on an even step is consumed (by the ALU or move mux) on the following odd write step.

## Test plan
- Reset: hold `reset`=0 for 3 cycles with `ins_valid`=1 → every output is at its reset value, nothing is accepted, and `ins_ready`=1 once reset=1.
- ALU, LENGTH=32, op=4'h3, srca=0x010, srcb=0x030, dst=0x050, accepted at T:
  - T+1: `addra`=0x010, `addrb`=0x030, `wea`=0.
  - T+2: `addra`=0x050, `wea`=1.
  - T+64: `addra`=0x06F, `wea`=1.
  - T+65..T+68: `wea`=0, `count`=64..67.
  - T+69: `done`=1.
- East move, srca=0x3FF:
  - T+1: `addra`=0x3FF, `addrb`=0x000, `east`=0.
  - T+2: `wea`=`web`=`east`=1.
  - T+4: `addra`=0x001, `addrb`=0x002.
  - T+33: `done`=1.
- Busy rejection: pulse `ins_valid` with kind 0 at T+10 of a running move → `ins_ready`=0 and the move completes unchanged.
- Reset at T+20 of an ALU op → T+21: `wea`=0, `count`=0, `busy`=0, no `done`; a new instruction is accepted right after reset.
- kind 6 accepted at T → `done`=1 at T+1 with no write enable ever high; a following south move accepted at T+1 runs normally with `south` high on odd steps.

Source files
------------

// File: rtl/pe_array_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pe_array_sequencer
//  Description : Issue-side sequencer for the 16-lane bit-serial PE array.
//                Accepts one instruction at a time (ALU op, neighbour move
//                or NOP) and drives the broadcast control bus that all PE
//                blocks consume in lockstep.
//  Revision    : 1.0 - initial release
// ============================================================================
module pe_array_sequencer #(
   parameter int LENGTH = 32,
   parameter int AW     = 10
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          ins_valid,
   output logic          ins_ready,
   input  logic [2:0]    ins_kind,
   input  logic [3:0]    ins_op,
   input  logic [AW-1:0] ins_srca,
   input  logic [AW-1:0] ins_srcb,
   input  logic [AW-1:0] ins_dst,
   output logic [AW-1:0] addra,
   output logic [AW-1:0] addrb,
   output logic          wea,
   output logic          web,
   output logic [3:0]    alu_sel,
   output logic [6:0]    count,
   output logic          east,
   output logic          west,
   output logic          south,
   output logic          north,
   output logic          busy,
   output logic          done
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_ALU_RUN  = 2'd1,
      S_MOVE_RUN = 2'd2
   } state_t;

   // Last step index of each run: ALU has 2*LENGTH compute steps plus 4 drain
   localparam logic [6:0] c_alu_last  = 7'(2 * LENGTH + 3);
   localparam logic [6:0] c_move_last = 7'(LENGTH - 1);
   localparam logic [6:0] c_alu_steps = 7'(2 * LENGTH);

   state_t        r_state, w_state_nxt;
   logic [6:0]    r_step,  w_step_nxt;
   logic [2:0]    r_kind,  w_kind_nxt;
   logic [3:0]    r_op,    w_op_nxt;
   logic [AW-1:0] r_srca,  w_srca_nxt;
   logic [AW-1:0] r_srcb,  w_srcb_nxt;
   logic [AW-1:0] r_dst,   w_dst_nxt;

   logic [AW-1:0] r_addra, w_addra_nxt;
   logic [AW-1:0] r_addrb, w_addrb_nxt;
   logic          r_wea,   w_wea_nxt;
   logic          r_web,   w_web_nxt;
   logic [3:0]    r_alu_sel, w_alu_sel_nxt;
   logic [6:0]    r_count, w_count_nxt;
   logic [3:0]    r_dir,   w_dir_nxt;     // {north, south, west, east}
   logic          r_done,  w_done_nxt;
   logic          r_busy;
   logic          r_ins_ready;

   logic [AW-1:0] w_half;                 // bit index i = step >> 1
   logic [AW-1:0] w_pair;                 // row offset 2j of the move pair

   // Next-state / next-output logic. Outputs are computed from the step that
   // will be presented next cycle so every output comes straight off a flop.
   always_comb begin
      w_state_nxt   = r_state;
      w_step_nxt    = r_step;
      w_kind_nxt    = r_kind;
      w_op_nxt      = r_op;
      w_srca_nxt    = r_srca;
      w_srcb_nxt    = r_srcb;
      w_dst_nxt     = r_dst;
      w_done_nxt    = 1'b0;
      w_addra_nxt   = r_addra;
      w_addrb_nxt   = r_addrb;
      w_wea_nxt     = 1'b0;
      w_web_nxt     = 1'b0;
      w_alu_sel_nxt = 4'd0;
      w_count_nxt   = 7'd0;
      w_dir_nxt     = 4'd0;
      w_half        = '0;
      w_pair        = '0;

      case (r_state)
         S_IDLE: begin
            if (ins_valid) begin
               w_kind_nxt = ins_kind;
               w_op_nxt   = ins_op;
               w_srca_nxt = ins_srca;
               w_srcb_nxt = ins_srcb;
               w_dst_nxt  = ins_dst;
               w_step_nxt = 7'd0;
               if (ins_kind == 3'd0) begin
                  w_state_nxt = S_ALU_RUN;
               end else if (ins_kind <= 3'd4) begin
                  w_state_nxt = S_MOVE_RUN;
               end else begin
                  w_done_nxt = 1'b1;     // NOP completes immediately
               end
            end
         end
         S_ALU_RUN: begin
            if (r_step == c_alu_last) begin
               w_state_nxt = S_IDLE;
               w_done_nxt  = 1'b1;
            end else begin
               w_step_nxt = r_step + 7'd1;
            end
         end
         S_MOVE_RUN: begin
            if (r_step == c_move_last) begin
               w_state_nxt = S_IDLE;
               w_done_nxt  = 1'b1;
            end else begin
               w_step_nxt = r_step + 7'd1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase

      w_half = AW'(w_step_nxt[6:1]);
      w_pair = AW'({w_step_nxt[6:1], 1'b0});

      case (w_state_nxt)
         S_ALU_RUN: begin
            w_count_nxt   = w_step_nxt;
            w_alu_sel_nxt = w_op_nxt;
            if (w_step_nxt < c_alu_steps) begin
               if (!w_step_nxt[0]) begin
                  // read step: fetch bit i of both operands
                  w_addra_nxt = w_srca_nxt + w_half;
                  w_addrb_nxt = w_srcb_nxt + w_half;
               end else begin
                  // write step: result bit i through port A
                  w_addra_nxt = w_dst_nxt + w_half;
                  w_wea_nxt   = 1'b1;
               end
            end
         end
         S_MOVE_RUN: begin
            w_addra_nxt = w_srca_nxt + w_pair;
            w_addrb_nxt = w_srca_nxt + w_pair + AW'(1);
            if (w_step_nxt[0]) begin
               w_wea_nxt = 1'b1;
               w_web_nxt = 1'b1;
               case (w_kind_nxt)
                  3'd1:    w_dir_nxt = 4'b0001;
                  3'd2:    w_dir_nxt = 4'b0010;
                  3'd3:    w_dir_nxt = 4'b0100;
                  3'd4:    w_dir_nxt = 4'b1000;
                  default: w_dir_nxt = 4'b0000;
               endcase
            end
         end
         default: ;
      endcase
   end

   // State, latched instruction and registered control outputs
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_step      <= 7'd0;
         r_kind      <= 3'd0;
         r_op        <= 4'd0;
         r_srca      <= '0;
         r_srcb      <= '0;
         r_dst       <= '0;
         r_addra     <= '0;
         r_addrb     <= '0;
         r_wea       <= 1'b0;
         r_web       <= 1'b0;
         r_alu_sel   <= 4'd0;
         r_count     <= 7'd0;
         r_dir       <= 4'd0;
         r_done      <= 1'b0;
         r_busy      <= 1'b0;
         r_ins_ready <= 1'b1;
      end else begin
         r_state     <= w_state_nxt;
         r_step      <= w_step_nxt;
         r_kind      <= w_kind_nxt;
         r_op        <= w_op_nxt;
         r_srca      <= w_srca_nxt;
         r_srcb      <= w_srcb_nxt;
         r_dst       <= w_dst_nxt;
         r_addra     <= w_addra_nxt;
         r_addrb     <= w_addrb_nxt;
         r_wea       <= w_wea_nxt;
         r_web       <= w_web_nxt;
         r_alu_sel   <= w_alu_sel_nxt;
         r_count     <= w_count_nxt;
         r_dir       <= w_dir_nxt;
         r_done      <= w_done_nxt;
         r_busy      <= (w_state_nxt != S_IDLE);
         r_ins_ready <= (w_state_nxt == S_IDLE);
      end
   end

   assign ins_ready = r_ins_ready;
   assign addra     = r_addra;
   assign addrb     = r_addrb;
   assign wea       = r_wea;
   assign web       = r_web;
   assign alu_sel   = r_alu_sel;
   assign count     = r_count;
   assign east      = r_dir[0];
   assign west      = r_dir[1];
   assign south     = r_dir[2];
   assign north     = r_dir[3];
   assign busy      = r_busy;
   assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_pe_array_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pe_array_sequencer
//  Description : Self-checking bench for pe_array_sequencer: a per-cycle
//                expected-output schedule built from the instruction rules,
//                directed scenarios with literal expectations, and random
//                instruction traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_array_sequencer;

   localparam int L  = 32;
   localparam int AW = 10;

   logic          clk;
   logic          reset;
   logic          ins_valid;
   logic          ins_ready;
   logic [2:0]    ins_kind;
   logic [3:0]    ins_op;
   logic [AW-1:0] ins_srca, ins_srcb, ins_dst;
   logic [AW-1:0] addra, addrb;
   logic          wea, web;
   logic [3:0]    alu_sel;
   logic [6:0]    count;
   logic          east, west, south, north, busy, done;

   int total = 0;
   int bad   = 0;

   pe_array_sequencer #(.LENGTH(L), .AW(AW)) dut (
      .clk(clk), .reset(reset), .ins_valid(ins_valid), .ins_ready(ins_ready),
      .ins_kind(ins_kind), .ins_op(ins_op), .ins_srca(ins_srca),
      .ins_srcb(ins_srcb), .ins_dst(ins_dst), .addra(addra), .addrb(addrb),
      .wea(wea), .web(web), .alu_sel(alu_sel), .count(count), .east(east),
      .west(west), .south(south), .north(north), .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [AW-1:0] addra;
      logic [AW-1:0] addrb;
      logic          wea;
      logic          web;
      logic [3:0]    alu_sel;
      logic [6:0]    count;
      logic          east;
      logic          west;
      logic          south;
      logic          north;
      logic          busy;
      logic          done;
      logic          ready;
   } exp_t;

   exp_t cur = '0;
   exp_t q[$];
   logic chk_on = 1'b0;

   // Reference model: on each accepted instruction, the full per-cycle
   // output trace is appended to a queue; one entry is consumed per cycle.
   always @(posedge clk) begin : model
      exp_t          e;
      exp_t          nxt;
      logic [AW-1:0] ha, hb;
      nxt = '0;
      if (!reset) begin
         q.delete();
         nxt.ready = 1'b1;
         chk_on <= 1'b1;
      end else begin
         if (ins_valid && cur.ready) begin
            ha = cur.addra;
            hb = cur.addrb;
            if (ins_kind == 3'd0) begin
               for (int c = 0; c < 2 * L + 4; c++) begin
                  e = '0;
                  e.busy = 1'b1;
                  e.count = 7'(c);
                  e.alu_sel = ins_op;
                  if (c < 2 * L) begin
                     if (c % 2 == 0) begin
                        ha = ins_srca + AW'(c / 2);
                        hb = ins_srcb + AW'(c / 2);
                     end else begin
                        ha = ins_dst + AW'(c / 2);
                        e.wea = 1'b1;
                     end
                  end
                  e.addra = ha;
                  e.addrb = hb;
                  q.push_back(e);
               end
            end else if (ins_kind <= 3'd4) begin
               for (int c = 0; c < L; c++) begin
                  e = '0;
                  e.busy = 1'b1;
                  ha = ins_srca + AW'((c / 2) * 2);
                  hb = ha + AW'(1);
                  if (c % 2 == 1) begin
                     e.wea   = 1'b1;
                     e.web   = 1'b1;
                     e.east  = (ins_kind == 3'd1);
                     e.west  = (ins_kind == 3'd2);
                     e.south = (ins_kind == 3'd3);
                     e.north = (ins_kind == 3'd4);
                  end
                  e.addra = ha;
                  e.addrb = hb;
                  q.push_back(e);
               end
            end
            e = '0;
            e.addra = ha;
            e.addrb = hb;
            e.done  = 1'b1;
            e.ready = 1'b1;
            q.push_back(e);
         end
         if (q.size() > 0) begin
            nxt = q.pop_front();
         end else begin
            nxt.addra = cur.addra;
            nxt.addrb = cur.addrb;
            nxt.ready = 1'b1;
         end
      end
      cur <= nxt;
   end

   // Cycle-by-cycle comparison of every output against the model
   always @(negedge clk) begin
      exp_t a;
      if (chk_on) begin
         a = {addra, addrb, wea, web, alu_sel, count, east, west, south,
              north, busy, done, ins_ready};
         total++;
         if (a !== cur) begin
            bad++;
            $display("FAIL cycle_compare t=%0t: dut=%h model=%h", $time, a, cur);
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, req);
      end
   endtask

   task automatic step(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic issue(input logic [2:0] k, input logic [3:0] op,
                        input logic [AW-1:0] a, input logic [AW-1:0] b,
                        input logic [AW-1:0] d);
      ins_valid = 1'b1;
      ins_kind  = k;
      ins_op    = op;
      ins_srca  = a;
      ins_srcb  = b;
      ins_dst   = d;
   endtask

   initial begin
      reset     = 1'b0;
      ins_valid = 1'b1;
      ins_kind  = 3'd0;
      ins_op    = 4'd0;
      ins_srca  = '0;
      ins_srcb  = '0;
      ins_dst   = '0;

      // Reset held with an instruction offered: nothing accepted
      step(3);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_addra", 32'(addra), 32'd0);
      reset     = 1'b1;
      ins_valid = 1'b0;
      step(1);
      chk("post_reset_ready", 32'(ins_ready), 32'd1);
      chk("post_reset_busy", 32'(busy), 32'd0);

      // Directed ALU operation
      issue(3'd0, 4'h3, 10'h010, 10'h030, 10'h050);
      step(1);
      ins_valid = 1'b0;
      chk("alu_t1_addra", 32'(addra), 32'h010);
      chk("alu_t1_addrb", 32'(addrb), 32'h030);
      chk("alu_t1_wea", 32'(wea), 32'd0);
      step(1);
      chk("alu_t2_addra", 32'(addra), 32'h050);
      chk("alu_t2_wea", 32'(wea), 32'd1);
      step(62);
      chk("alu_t64_addra", 32'(addra), 32'h06F);
      chk("alu_t64_wea", 32'(wea), 32'd1);
      step(1);
      for (int k = 0; k < 4; k++) begin
         chk("alu_drain_wea", 32'(wea), 32'd0);
         chk("alu_drain_count", 32'(count), 32'(64 + k));
         step(1);
      end
      chk("alu_done", 32'(done), 32'd1);

      // East move with address wrap, plus an ignored offer while busy
      issue(3'd1, 4'h0, 10'h3FF, 10'h000, 10'h000);
      step(1);
      ins_valid = 1'b0;
      chk("east_t1_addra", 32'(addra), 32'h3FF);
      chk("east_t1_addrb", 32'(addrb), 32'h000);
      chk("east_t1_east", 32'(east), 32'd0);
      step(1);
      chk("east_t2_we_strobe", 32'({wea, web, east}), 32'b111);
      step(2);
      chk("east_t4_addra", 32'(addra), 32'h001);
      chk("east_t4_addrb", 32'(addrb), 32'h002);
      step(6);
      issue(3'd0, 4'h5, 10'h111, 10'h222, 10'h333);
      chk("busy_ready", 32'(ins_ready), 32'd0);
      step(1);
      ins_valid = 1'b0;
      step(22);
      chk("east_done", 32'(done), 32'd1);

      // Reset in the middle of an ALU operation
      issue(3'd0, 4'h9, 10'h100, 10'h200, 10'h300);
      step(1);
      ins_valid = 1'b0;
      step(19);
      reset = 1'b0;
      step(1);
      chk("abort_wea", 32'(wea), 32'd0);
      chk("abort_count", 32'(count), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      reset = 1'b1;
      issue(3'd2, 4'h0, 10'h040, 10'h000, 10'h000);
      step(1);
      ins_valid = 1'b0;
      chk("post_abort_accept", 32'(busy), 32'd1);
      step(L + 2);

      // NOP followed immediately by a south move
      issue(3'd6, 4'h0, 10'h000, 10'h000, 10'h000);
      step(1);
      chk("nop_done", 32'(done), 32'd1);
      chk("nop_wea", 32'(wea), 32'd0);
      issue(3'd3, 4'h0, 10'h0A0, 10'h000, 10'h000);
      step(1);
      ins_valid = 1'b0;
      chk("south_even", 32'(south), 32'd0);
      step(1);
      chk("south_odd", 32'({south, wea, web}), 32'b111);
      step(L + 2);

      // Random traffic, including occasional resets
      for (int n = 0; n < 1500; n++) begin
         ins_valid = ($urandom_range(0, 3) == 0);
         ins_kind  = 3'($urandom_range(0, 7));
         ins_op    = 4'($urandom);
         ins_srca  = AW'($urandom);
         ins_srcb  = AW'($urandom);
         ins_dst   = AW'($urandom);
         reset     = ($urandom_range(0, 199) != 0);
         step(1);
      end
      reset     = 1'b1;
      ins_valid = 1'b0;
      step(2 * L + 8);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
